mem_arbiter: RTL and testbench

Shares one synchronous single-port memory between two processor-style requesters (core 0 and core 1, or core and loader). Each requester uses the same read/write plus `hit` completion handshake the processor already uses toward memory. The arbiter grants the memory to one requester at a time, round-robin, and returns read data and a one-cycle `hit` to that requester only. It sits between the processor memory buses (`address_out`/`memory_out`/`memory_in`/`hit`) and the block RAM.

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the two processor-side request buses and the single-port memory
// bus that the arbiter sits between, plus the arbiter status outputs.
//   req0_* / req1_* : read/write request, address, write data, read data, hit
//   mem_*           : registered address/write data/write enable, read data
//   busy, owner     : arbiter status
// Modports:
//   slave  - the arbiter's view (serves requesters, drives the memory bus)
//   master - the environment's view (requesters plus the memory itself)
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0_rd;
  logic              req0_wr;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [DATA_W-1:0] req0_rdata;
  logic              req0_hit;

  logic              req1_rd;
  logic              req1_wr;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [DATA_W-1:0] req1_rdata;
  logic              req1_hit;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  req0_rd, req0_wr, req0_addr, req0_wdata,
    input  req1_rd, req1_wr, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_rdata, req0_hit, req1_rdata, req1_hit,
    output mem_addr, mem_wdata, mem_we,
    output busy, owner
  );

  modport master (
    output req0_rd, req0_wr, req0_addr, req0_wdata,
    output req1_rd, req1_wr, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_rdata, req0_hit, req1_rdata, req1_hit,
    input  mem_addr, mem_wdata, mem_we,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter sharing one synchronous single-port memory between two
// processor-style requesters. One transaction is in flight at a time; the
// granted port alone sees the read data and the one-cycle hit pulse.
// Ports:
//   clk_100 : system clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : mem_arbiter_if.slave - both request buses, memory bus, busy/owner
// Parameters:
//   ADDR_W, DATA_W : address / data width
//   MEM_LAT        : memory read latency (1..4) from the edge that samples
//                    mem_addr to the edge where mem_rdata is captured
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic         clk_100,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] LAT_C = 3'(MEM_LAT);

  state_t            state_r;
  logic [2:0]        cnt_r;
  logic              op_wr_r;
  logic              owner_r;
  logic              busy_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_we_r;
  logic              hit0_r;
  logic              hit1_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;

  logic              req0_s;
  logic              req1_s;
  logic              grant_valid_s;
  logic              grant_idx_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_wr_s;

  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.req0_hit   = hit0_r;
  assign bus.req1_hit   = hit1_r;
  assign bus.req0_rdata = rdata0_r;
  assign bus.req1_rdata = rdata1_r;
  assign bus.busy       = busy_r;
  assign bus.owner      = owner_r;

  // Round-robin grant decision: on contention the port that did not own the
  // memory last wins, so owner resetting to 1 favours port 0 first.
  always_comb begin
    req0_s        = bus.req0_rd | bus.req0_wr;
    req1_s        = bus.req1_rd | bus.req1_wr;
    grant_valid_s = req0_s | req1_s;
    if (req0_s && req1_s) begin
      grant_idx_s = ~owner_r;
    end else if (req0_s) begin
      grant_idx_s = 1'b0;
    end else if (req1_s) begin
      grant_idx_s = 1'b1;
    end else begin
      grant_idx_s = owner_r;
    end
  end

  // Select the granted port's address, data and operation (wr wins over rd).
  always_comb begin
    sel_addr_s  = bus.req0_addr;
    sel_wdata_s = bus.req0_wdata;
    sel_wr_s    = bus.req0_wr;
    if (grant_idx_s) begin
      sel_addr_s  = bus.req1_addr;
      sel_wdata_s = bus.req1_wdata;
      sel_wr_s    = bus.req1_wr;
    end else begin
      sel_addr_s  = bus.req0_addr;
      sel_wdata_s = bus.req0_wdata;
      sel_wr_s    = bus.req0_wr;
    end
  end

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      op_wr_r     <= 1'b0;
      owner_r     <= 1'b1;
      busy_r      <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_we_r    <= 1'b0;
      hit0_r      <= 1'b0;
      hit1_r      <= 1'b0;
      rdata0_r    <= '0;
      rdata1_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          hit0_r <= 1'b0;
          hit1_r <= 1'b0;
          if (grant_valid_s) begin
            // The memory bus registers are loaded here, so ACCESS presents
            // the latched request and later requester changes are ignored.
            owner_r     <= grant_idx_s;
            op_wr_r     <= sel_wr_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
            mem_we_r    <= sel_wr_s;
            busy_r      <= 1'b1;
            state_r     <= ACCESS;
          end else begin
            mem_we_r <= 1'b0;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
        end

        ACCESS: begin
          mem_we_r <= 1'b0;
          if (op_wr_r) begin
            // The memory commits the write on this edge; complete at once.
            hit0_r  <= ~owner_r;
            hit1_r  <= owner_r;
            state_r <= RESP;
          end else begin
            cnt_r   <= LAT_C;
            state_r <= WAIT;
          end
        end

        WAIT: begin
          // A count of 0 can only come from a corrupted state; treat it as
          // expired rather than wrapping and stalling for eight cycles.
          if (cnt_r <= 3'd1) begin
            cnt_r <= 3'd0;
            if (owner_r) begin
              rdata1_r <= bus.mem_rdata;
              hit1_r   <= 1'b1;
            end else begin
              rdata0_r <= bus.mem_rdata;
              hit0_r   <= 1'b1;
            end
            state_r <= RESP;
          end else begin
            cnt_r   <= cnt_r - 3'd1;
            state_r <= WAIT;
          end
        end

        RESP: begin
          hit0_r   <= 1'b0;
          hit1_r   <= 1'b0;
          mem_we_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end

        default: begin
          hit0_r   <= 1'b0;
          hit1_r   <= 1'b0;
          mem_we_r <= 1'b0;
          busy_r   <= 1'b0;
          cnt_r    <= 3'd0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter. Two instances are built, one
// with MEM_LAT=1 and one with MEM_LAT=3, each with its own memory model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Window k below means the half-cycle after rising edge E(k), where E0 is the
// edge that first sees the request.
module tb_mem_arbiter;
  logic clk_100 = 1'b0;
  logic rst     = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_100 = ~clk_100;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus3 ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
    .clk_100 (clk_100),
    .rst     (rst),
    .bus     (bus1)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u_dut3 (
    .clk_100 (clk_100),
    .rst     (rst),
    .bus     (bus3)
  );

  // Memory models: word i initialised to 0x5A00+i, registered read pipeline
  // of depth MEM_LAT.
  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];
  logic [15:0] pipe1;
  logic [15:0] pipe3 [0:2];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 16'h5A00 + 16'(i);
      mem3[i] = 16'h5A00 + 16'(i);
    end
  end

  always @(posedge clk_100) begin
    if (bus1.mem_we) mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    pipe1 <= mem1[bus1.mem_addr[7:0]];
  end
  assign bus1.mem_rdata = pipe1;

  always @(posedge clk_100) begin
    if (bus3.mem_we) mem3[bus3.mem_addr[7:0]] <= bus3.mem_wdata;
    pipe3[0] <= mem3[bus3.mem_addr[7:0]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus3.mem_rdata = pipe3[2];

  task automatic idle_inputs();
    bus1.req0_rd = 1'b0; bus1.req0_wr = 1'b0; bus1.req0_addr = 16'h0000; bus1.req0_wdata = 16'h0000;
    bus1.req1_rd = 1'b0; bus1.req1_wr = 1'b0; bus1.req1_addr = 16'h0000; bus1.req1_wdata = 16'h0000;
    bus3.req0_rd = 1'b0; bus3.req0_wr = 1'b0; bus3.req0_addr = 16'h0000; bus3.req0_wdata = 16'h0000;
    bus3.req1_rd = 1'b0; bus3.req1_wr = 1'b0; bus3.req1_addr = 16'h0000; bus3.req1_wdata = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk_100);
    rst = 1'b1;
    repeat (2) @(negedge clk_100);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus1.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_addr: got %h expected 0000", bus1.mem_addr); end
    n_checks++; if (bus1.mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_wdata: got %h expected 0000", bus1.mem_wdata); end
    n_checks++; if (bus1.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b expected 0", bus1.mem_we); end
    n_checks++; if ({bus1.req0_hit, bus1.req1_hit} !== 2'b00) begin n_fail++; $display("FAIL rst_hits: got %b%b expected 00", bus1.req0_hit, bus1.req1_hit); end
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus1.busy); end
    n_checks++; if (bus1.owner !== 1'b1) begin n_fail++; $display("FAIL rst_owner: got %b expected 1", bus1.owner); end
    n_checks++; if ({bus1.req0_rdata, bus1.req1_rdata} !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h %h expected 0000 0000", bus1.req0_rdata, bus1.req1_rdata); end
    n_checks++; if ({bus3.busy, bus3.owner, bus3.mem_we} !== 3'b010) begin n_fail++; $display("FAIL rst_lat3: got busy/owner/we %b%b%b expected 010", bus3.busy, bus3.owner, bus3.mem_we); end
  endtask

  task automatic test_write();
    int we_cnt = 0;
    bus1.req0_wr = 1'b1; bus1.req0_addr = 16'h0010; bus1.req0_wdata = 16'hBEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_100);
      if (bus1.mem_we === 1'b1) we_cnt++;
      n_checks++; if (bus1.req1_hit !== 1'b0) begin n_fail++; $display("FAIL wr_hit1 k=%0d: got %b expected 0", k, bus1.req1_hit); end
      n_checks++; if (bus1.req0_hit !== 1'(k == 1)) begin n_fail++; $display("FAIL wr_hit0 k=%0d: got %b expected %b", k, bus1.req0_hit, (k == 1)); end
      if (k == 0) begin
        n_checks++; if ({bus1.mem_we, bus1.mem_addr, bus1.mem_wdata} !== {1'b1, 16'h0010, 16'hBEEF}) begin n_fail++; $display("FAIL wr_bus: got we=%b addr=%h data=%h expected 1 0010 beef", bus1.mem_we, bus1.mem_addr, bus1.mem_wdata); end
        n_checks++; if ({bus1.busy, bus1.owner} !== 2'b10) begin n_fail++; $display("FAIL wr_busy_owner: got %b%b expected 10", bus1.busy, bus1.owner); end
      end
      if (k == 1) bus1.req0_wr = 1'b0;
    end
    n_checks++; if (we_cnt !== 1) begin n_fail++; $display("FAIL wr_we_cycles: got %0d expected 1", we_cnt); end
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle: got busy %b expected 0", bus1.busy); end
  endtask

  task automatic test_read_port1();
    bus1.req1_rd = 1'b1; bus1.req1_addr = 16'h0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_100);
      n_checks++; if (bus1.req0_hit !== 1'b0) begin n_fail++; $display("FAIL rd1_hit0 k=%0d: got %b expected 0", k, bus1.req0_hit); end
      n_checks++; if (bus1.req1_hit !== 1'(k == 2)) begin n_fail++; $display("FAIL rd1_hit1 k=%0d: got %b expected %b", k, bus1.req1_hit, (k == 2)); end
      if (k == 0) begin
        n_checks++; if ({bus1.owner, bus1.mem_we, bus1.mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin n_fail++; $display("FAIL rd1_grant: got owner=%b we=%b addr=%h expected 1 0 0010", bus1.owner, bus1.mem_we, bus1.mem_addr); end
      end
      if (k == 2) begin
        n_checks++; if (bus1.req1_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd1_data: got %h expected beef", bus1.req1_rdata); end
        bus1.req1_rd = 1'b0;
      end
    end
    n_checks++; if (bus1.req0_rdata !== 16'h0000) begin n_fail++; $display("FAIL rd1_rdata0_kept: got %h expected 0000", bus1.req0_rdata); end
    n_checks++; if ({bus1.busy, bus1.req1_rdata} !== {1'b0, 16'hBEEF}) begin n_fail++; $display("FAIL rd1_after: got busy=%b rdata1=%h expected 0 beef", bus1.busy, bus1.req1_rdata); end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus1.req0_rd = 1'b1; bus1.req0_addr = 16'h0001;
    bus1.req1_rd = 1'b1; bus1.req1_addr = 16'h0002;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_100);
      n_checks++; if (bus1.req0_hit !== 1'(k == 2 || k == 10)) begin n_fail++; $display("FAIL rr_hit0 k=%0d: got %b expected %b", k, bus1.req0_hit, (k == 2 || k == 10)); end
      n_checks++; if (bus1.req1_hit !== 1'(k == 6 || k == 14)) begin n_fail++; $display("FAIL rr_hit1 k=%0d: got %b expected %b", k, bus1.req1_hit, (k == 6 || k == 14)); end
      if (k % 4 == 0) begin
        n_checks++; if (bus1.owner !== 1'((k / 4) % 2)) begin n_fail++; $display("FAIL rr_owner k=%0d: got %b expected %0d", k, bus1.owner, (k / 4) % 2); end
      end
      if (k == 2) begin
        n_checks++; if (bus1.req0_rdata !== 16'h5A01) begin n_fail++; $display("FAIL rr_data0: got %h expected 5a01", bus1.req0_rdata); end
      end
      if (k == 6) begin
        n_checks++; if (bus1.req1_rdata !== 16'h5A02) begin n_fail++; $display("FAIL rr_data1: got %h expected 5a02", bus1.req1_rdata); end
      end
      if (k == 15) begin
        bus1.req0_rd = 1'b0;
        bus1.req1_rd = 1'b0;
      end
    end
    repeat (2) @(negedge clk_100);
  endtask

  task automatic test_rd_wr_both();
    bus1.req0_rd = 1'b1; bus1.req0_wr = 1'b1; bus1.req0_addr = 16'h0005; bus1.req0_wdata = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_100);
      if (k == 0) begin
        n_checks++; if ({bus1.mem_we, bus1.mem_addr, bus1.mem_wdata} !== {1'b1, 16'h0005, 16'h1234}) begin n_fail++; $display("FAIL rw_bus: got we=%b addr=%h data=%h expected 1 0005 1234", bus1.mem_we, bus1.mem_addr, bus1.mem_wdata); end
      end
      if (k == 1) begin
        n_checks++; if ({bus1.req0_hit, bus1.req0_rdata} !== {1'b1, 16'h5A01}) begin n_fail++; $display("FAIL rw_hit: got hit=%b rdata0=%h expected 1 5a01", bus1.req0_hit, bus1.req0_rdata); end
        bus1.req0_rd = 1'b0; bus1.req0_wr = 1'b0;
      end
    end
    bus1.req0_rd = 1'b1; bus1.req0_addr = 16'h0005;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_100);
      n_checks++; if (bus1.req0_hit !== 1'(k == 2)) begin n_fail++; $display("FAIL rw_rd_hit k=%0d: got %b expected %b", k, bus1.req0_hit, (k == 2)); end
      if (k == 2) begin
        n_checks++; if (bus1.req0_rdata !== 16'h1234) begin n_fail++; $display("FAIL rw_rd_data: got %h expected 1234", bus1.req0_rdata); end
        bus1.req0_rd = 1'b0;
      end
    end
  endtask

  task automatic test_lat3();
    int busy_cnt = 0;
    bus3.req0_rd = 1'b1; bus3.req0_addr = 16'h0007;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_100);
      if (bus3.busy === 1'b1) busy_cnt++;
      n_checks++; if (bus3.req0_hit !== 1'(k == 4)) begin n_fail++; $display("FAIL lat3_hit0 k=%0d: got %b expected %b", k, bus3.req0_hit, (k == 4)); end
      n_checks++; if (bus3.req1_hit !== 1'b0) begin n_fail++; $display("FAIL lat3_hit1 k=%0d: got %b expected 0", k, bus3.req1_hit); end
      if (k == 4) begin
        n_checks++; if (bus3.req0_rdata !== 16'h5A07) begin n_fail++; $display("FAIL lat3_data: got %h expected 5a07", bus3.req0_rdata); end
        bus3.req0_rd = 1'b0;
      end
    end
    n_checks++; if (busy_cnt !== 5) begin n_fail++; $display("FAIL lat3_busy_cycles: got %0d expected 5", busy_cnt); end
  endtask

  task automatic test_reset_mid();
    bus1.req1_rd = 1'b1; bus1.req1_addr = 16'h0002;
    @(negedge clk_100);
    n_checks++; if ({bus1.busy, bus1.owner} !== 2'b11) begin n_fail++; $display("FAIL mid_grant: got busy/owner %b%b expected 11", bus1.busy, bus1.owner); end
    @(negedge clk_100);
    rst = 1'b1;
    bus1.req1_rd = 1'b0;
    @(negedge clk_100);
    n_checks++; if ({bus1.busy, bus1.req0_hit, bus1.req1_hit, bus1.owner} !== 4'b0001) begin n_fail++; $display("FAIL mid_reset: got busy/hit0/hit1/owner %b%b%b%b expected 0001", bus1.busy, bus1.req0_hit, bus1.req1_hit, bus1.owner); end
    n_checks++; if ({bus1.mem_addr, bus1.req0_rdata, bus1.req1_rdata} !== 48'h0) begin n_fail++; $display("FAIL mid_regs: got addr=%h rd0=%h rd1=%h expected zeros", bus1.mem_addr, bus1.req0_rdata, bus1.req1_rdata); end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_100);
      n_checks++; if ({bus1.req0_hit, bus1.req1_hit} !== 2'b00) begin n_fail++; $display("FAIL mid_nohit k=%0d: got %b%b expected 00", k, bus1.req0_hit, bus1.req1_hit); end
    end
    bus1.req0_rd = 1'b1; bus1.req0_addr = 16'h0001;
    bus1.req1_rd = 1'b1; bus1.req1_addr = 16'h0002;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_100);
      if (k == 0) begin
        n_checks++; if (bus1.owner !== 1'b0) begin n_fail++; $display("FAIL mid_regrant: got owner %b expected 0", bus1.owner); end
      end
      if (k == 2) begin
        n_checks++; if ({bus1.req0_hit, bus1.req0_rdata} !== {1'b1, 16'h5A01}) begin n_fail++; $display("FAIL mid_read: got hit0=%b rdata0=%h expected 1 5a01", bus1.req0_hit, bus1.req0_rdata); end
        bus1.req0_rd = 1'b0;
        bus1.req1_rd = 1'b0;
      end
    end
    repeat (3) @(negedge clk_100);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write();
    test_read_port1();
    test_round_robin();
    test_rd_wr_both();
    test_lat3();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
